// File: rtl/mpt_pkg.sv
// MPT walker shared types: transaction payload, mode encodings, MPTE fields,
// fault causes, walk FSM states and table-index helpers.
package mpt_pkg;

  localparam int unsigned SPA_WIDTH    = 64;
  localparam int unsigned PPN_WIDTH    = 44;
  localparam int unsigned LVL_WIDTH    = 3;
  localparam int unsigned IDX_WIDTH    = 9;
  localparam int unsigned PAGE_SHIFT   = 12;
  localparam int unsigned MPTE_V       = 0;
  localparam int unsigned MPTE_L       = 1;
  localparam int unsigned MPTE_PPN_LSB = 10;
  localparam int unsigned MPTE_PPN_MSB = 53;

  typedef enum logic [3:0] {
    MPT_BARE    = 4'd0,
    MPT_SMMPT43 = 4'd1,
    MPT_SMMPT52 = 4'd2,
    MPT_SMMPT64 = 4'd3
  } mpt_mode_e;

  typedef struct packed {
    mpt_mode_e              mode;
    logic [15:0]            sdid;
    logic [PPN_WIDTH-1:0]   ppn;
  } mmpt_t;

  typedef struct packed {
    mmpt_t                  mmpt;
    logic [SPA_WIDTH-1:0]   spa;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_FORMAT  = 2'd1,
    FAULT_INVALID = 2'd2,
    FAULT_ACCESS  = 2'd3
  } mpt_fault_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_RESULT   = 3'd3,
    S_DRAIN    = 3'd4
  } mpt_walk_state_e;

  // Table depth per mode; BARE never reaches the walker (rejected upstream).
  function automatic logic [LVL_WIDTH-1:0] mpt_levels(input mpt_mode_e mode);
    case (mode)
      MPT_SMMPT43: return LVL_WIDTH'(3);
      MPT_SMMPT52: return LVL_WIDTH'(4);
      MPT_SMMPT64: return LVL_WIDTH'(5);
      default:     return LVL_WIDTH'(1);
    endcase
  endfunction

  // 9-bit table index for a level: spa[20+9*level : 12+9*level].
  function automatic logic [IDX_WIDTH-1:0] mpt_index(input logic [SPA_WIDTH-1:0] spa,
                                                     input mpt_mode_e mode,
                                                     input logic [LVL_WIDTH-1:0] level);
    if (level >= mpt_levels(mode)) return '0;
    return IDX_WIDTH'(spa >> (PAGE_SHIFT + IDX_WIDTH * 32'(level)));
  endfunction

endpackage

// File: rtl/mpt_walk_stage_if.sv
// MPTE memory read port: valid/ready request, always-accepted response.
//   master: walker (drives req_valid/req_addr)
//   slave : memory (drives req_ready and the response)
interface mpt_mem_if #(
  parameter int unsigned PA_WIDTH   = 64,
  parameter int unsigned MPTE_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [PA_WIDTH-1:0]   req_addr;
  logic                  rsp_valid;
  logic [MPTE_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mpt_addr_gen.sv
// MPTE byte address for one walk level: base + (index << 3).
//   base/spa/mode/level in, addr_c out (combinational).
module mpt_addr_gen
  import mpt_pkg::*;
#(
  parameter int unsigned PA_WIDTH = 64
) (
  input  logic [PA_WIDTH-1:0]  base,
  input  logic [SPA_WIDTH-1:0] spa,
  input  mpt_mode_e            mode,
  input  logic [LVL_WIDTH-1:0] level,
  output logic [PA_WIDTH-1:0]  addr_c
);

  assign addr_c = base + PA_WIDTH'({mpt_index(spa, mode, level), 3'b000});

endmodule

// File: rtl/mpt_walk_stage.sv
// MPT walk stage: accepts one format-checked transaction, walks the memory
// protection table one MPTE read per level, returns leaf MPTE or fault cause.
//   clk_i/rst_ni           clock, async active-low reset
//   cf_*                   transaction in from check-format stage, walk_ready_o
//   flush_i                abort current walk
//   mem                    MPTE read port (master side)
//   walk_*                 result out to permission-check stage
module mpt_walk_stage
  import mpt_pkg::*;
#(
  parameter int unsigned PA_WIDTH   = 64,
  parameter int unsigned MPTE_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  mptw_transaction_t      cf_transaction_i,
  input  logic                   cf_valid_i,
  input  logic                   cf_format_error_i,
  output logic                   walk_ready_o,
  input  logic                   flush_i,
  mpt_mem_if.master              mem,
  output logic                   walk_valid_o,
  input  logic                   walk_ready_i,
  output mptw_transaction_t      walk_transaction_o,
  output logic [MPTE_WIDTH-1:0]  walk_mpte_o,
  output logic                   walk_fault_o,
  output logic [1:0]             walk_fault_cause_o
);

  mpt_walk_state_e        state_q, state_d;
  mptw_transaction_t      txn_q, txn_d;
  logic [PA_WIDTH-1:0]    base_q, base_d;
  logic [LVL_WIDTH-1:0]   level_q, level_d;
  logic [MPTE_WIDTH-1:0]  mpte_q, mpte_d;
  logic                   fault_q, fault_d;
  mpt_fault_e             cause_q, cause_d;
  logic [PA_WIDTH-1:0]    addr_c;
  logic [PA_WIDTH-1:0]    addr_q;
  logic                   req_valid_q, ready_q, walk_valid_q;

  // Address is computed from next-state values so the request port is a flop.
  mpt_addr_gen #(.PA_WIDTH(PA_WIDTH)) u_addr_gen (
    .base   (base_d),
    .spa    (txn_d.spa),
    .mode   (txn_d.mmpt.mode),
    .level  (level_d),
    .addr_c (addr_c)
  );

  // Next-state and datapath updates; flush takes priority over everything.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    base_d  = base_q;
    level_d = level_q;
    mpte_d  = mpte_q;
    fault_d = fault_q;
    cause_d = cause_q;

    unique case (state_q)
      S_IDLE: begin
        if (!flush_i && cf_valid_i) begin
          txn_d  = cf_transaction_i;
          mpte_d = '0;
          if (cf_format_error_i) begin
            fault_d = 1'b1;
            cause_d = FAULT_FORMAT;
            state_d = S_RESULT;
          end else begin
            fault_d = 1'b0;
            cause_d = FAULT_NONE;
            level_d = mpt_levels(cf_transaction_i.mmpt.mode) - LVL_WIDTH'(1);
            base_d  = PA_WIDTH'({cf_transaction_i.mmpt.ppn, 12'b0});
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A request accepted alongside the flush is in flight: drain it.
        if (mem.req_ready)  state_d = flush_i ? S_DRAIN : S_WAIT_RSP;
        else if (flush_i)   state_d = S_IDLE;
      end

      S_WAIT_RSP: begin
        if (mem.rsp_valid) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (mem.rsp_err) begin
            fault_d = 1'b1;
            cause_d = FAULT_ACCESS;
            state_d = S_RESULT;
          end else if (!mem.rsp_data[MPTE_V]) begin
            fault_d = 1'b1;
            cause_d = FAULT_INVALID;
            state_d = S_RESULT;
          end else if (mem.rsp_data[MPTE_L]) begin
            mpte_d  = mem.rsp_data;
            state_d = S_RESULT;
          end else if (level_q == '0) begin
            fault_d = 1'b1;
            cause_d = FAULT_INVALID;
            state_d = S_RESULT;
          end else begin
            base_d  = PA_WIDTH'({mem.rsp_data[MPTE_PPN_MSB:MPTE_PPN_LSB], 12'b0});
            level_d = level_q - LVL_WIDTH'(1);
            state_d = S_REQ;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end

      S_RESULT: begin
        if (flush_i || walk_ready_i) state_d = S_IDLE;
      end

      S_DRAIN: begin
        if (mem.rsp_valid) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      txn_q        <= '0;
      base_q       <= '0;
      level_q      <= '0;
      mpte_q       <= '0;
      fault_q      <= 1'b0;
      cause_q      <= FAULT_NONE;
      addr_q       <= '0;
      req_valid_q  <= 1'b0;
      ready_q      <= 1'b1;
      walk_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      base_q       <= base_d;
      level_q      <= level_d;
      mpte_q       <= mpte_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      addr_q       <= addr_c;
      req_valid_q  <= (state_d == S_REQ);
      ready_q      <= (state_d == S_IDLE);
      walk_valid_q <= (state_d == S_RESULT);
    end
  end

  assign mem.req_valid          = req_valid_q;
  assign mem.req_addr           = addr_q;
  assign walk_ready_o           = ready_q;
  assign walk_valid_o           = walk_valid_q;
  assign walk_transaction_o     = txn_q;
  assign walk_mpte_o            = mpte_q;
  assign walk_fault_o           = fault_q;
  assign walk_fault_cause_o     = cause_q;

endmodule

// File: tb/tb_mpt_walk_stage.sv
// Directed bench for mpt_walk_stage with hand-computed addresses and results.
module tb_mpt_walk_stage;
  import mpt_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  mptw_transaction_t cf_transaction;
  logic              cf_valid = 1'b0;
  logic              cf_format_error = 1'b0;
  logic              walk_ready_o;
  logic              flush = 1'b0;
  logic              walk_valid_o;
  logic              walk_ready_i = 1'b0;
  mptw_transaction_t walk_transaction_o;
  logic [63:0]       walk_mpte_o;
  logic              walk_fault_o;
  logic [1:0]        walk_fault_cause_o;

  int checks = 0;
  int failures = 0;

  mpt_mem_if #(.PA_WIDTH(64), .MPTE_WIDTH(64)) mem_if ();

  mpt_walk_stage #(.PA_WIDTH(64), .MPTE_WIDTH(64)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cf_transaction_i   (cf_transaction),
    .cf_valid_i         (cf_valid),
    .cf_format_error_i  (cf_format_error),
    .walk_ready_o       (walk_ready_o),
    .flush_i            (flush),
    .mem                (mem_if),
    .walk_valid_o       (walk_valid_o),
    .walk_ready_i       (walk_ready_i),
    .walk_transaction_o (walk_transaction_o),
    .walk_mpte_o        (walk_mpte_o),
    .walk_fault_o       (walk_fault_o),
    .walk_fault_cause_o (walk_fault_cause_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mpt_mode_e mode, input logic [43:0] ppn,
                      input logic [63:0] spa, input logic fmt);
    chk("ready_before_accept", 64'(walk_ready_o), 64'd1);
    cf_transaction.mmpt.mode = mode;
    cf_transaction.mmpt.sdid = 16'h00a5;
    cf_transaction.mmpt.ppn  = ppn;
    cf_transaction.spa       = spa;
    cf_valid        = 1'b1;
    cf_format_error = fmt;
    tick();
    cf_valid        = 1'b0;
    cf_format_error = 1'b0;
  endtask

  // Zero-wait memory: accept the pending request, respond the next cycle.
  task automatic serve(input string tag, input logic [63:0] exp_addr,
                       input logic [63:0] data, input logic err);
    int n = 0;
    while (!mem_if.req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_valid"}, 64'(mem_if.req_valid), 64'd1);
    chk({tag, "_req_addr"}, mem_if.req_addr, exp_addr);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b1;
    mem_if.rsp_data  = data;
    mem_if.rsp_err   = err;
    tick();
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_data  = '0;
    mem_if.rsp_err   = 1'b0;
  endtask

  // Result must be valid now (one cycle after accept / last response).
  task automatic result(input string tag, input logic fault, input logic [1:0] cause,
                        input logic [63:0] mpte);
    chk({tag, "_walk_valid"}, 64'(walk_valid_o), 64'd1);
    chk({tag, "_no_extra_req"}, 64'(mem_if.req_valid), 64'd0);
    chk({tag, "_fault"}, 64'(walk_fault_o), 64'(fault));
    chk({tag, "_cause"}, 64'(walk_fault_cause_o), 64'(cause));
    chk({tag, "_mpte"}, walk_mpte_o, mpte);
    walk_ready_i = 1'b1;
    tick();
    walk_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 64'(walk_valid_o), 64'd0);
    chk({tag, "_ready_back"}, 64'(walk_ready_o), 64'd1);
  endtask

  localparam logic [63:0] SPA_A = 64'h0000_0040_2000_3000;

  initial begin
    cf_transaction   = '0;
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_data  = '0;
    mem_if.rsp_err   = 1'b0;

    // Reset values
    #12;
    chk("rst_walk_ready", 64'(walk_ready_o), 64'd1);
    chk("rst_walk_valid", 64'(walk_valid_o), 64'd0);
    chk("rst_req_valid", 64'(mem_if.req_valid), 64'd0);
    chk("rst_req_addr", mem_if.req_addr, 64'd0);
    chk("rst_fault", 64'(walk_fault_o), 64'd0);
    chk("rst_cause", 64'(walk_fault_cause_o), 64'd0);
    chk("rst_mpte", walk_mpte_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Format error: no memory traffic, result next cycle with cause 1
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b1);
    chk("fmt_spa", walk_transaction_o.spa, SPA_A);
    result("fmt", 1'b1, 2'd1, 64'd0);

    // SMMPT43 three-level walk: idx2=0x100, idx1=0x100, idx0=0x3
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b0);
    chk("w43_req_latency", 64'(mem_if.req_valid), 64'd1);
    serve("w43_l2", 64'h8000_0800, 64'h2000_0401, 1'b0);
    serve("w43_l1", 64'h8000_1800, 64'h2000_0801, 1'b0);
    serve("w43_l0", 64'h8000_2018, 64'h2000_0C03, 1'b0);
    result("w43", 1'b0, 2'd0, 64'h2000_0C03);

    // Invalid first MPTE: one request, cause 2
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b0);
    serve("inv_l2", 64'h8000_0800, 64'h0, 1'b0);
    result("inv", 1'b1, 2'd2, 64'd0);

    // SMMPT52, all non-leaf: four requests then cause 2
    send(MPT_SMMPT52, 44'h80000, 64'h0, 1'b0);
    serve("nl_l3", 64'h8000_0000, 64'h2000_0401, 1'b0);
    serve("nl_l2", 64'h8000_1000, 64'h2000_0401, 1'b0);
    serve("nl_l1", 64'h8000_1000, 64'h2000_0401, 1'b0);
    serve("nl_l0", 64'h8000_1000, 64'h2000_0401, 1'b0);
    result("nl", 1'b1, 2'd2, 64'd0);

    // Bus error on level 1: cause 3
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b0);
    serve("berr_l2", 64'h8000_0800, 64'h2000_0401, 1'b0);
    serve("berr_l1", 64'h8000_1800, 64'h2000_0C03, 1'b1);
    result("berr", 1'b1, 2'd3, 64'd0);

    // Request backpressure: address held while ready is low
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid_hold", 64'(mem_if.req_valid), 64'd1);
      chk("bp_addr_hold", mem_if.req_addr, 64'h8000_0800);
      tick();
    end
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    // Flush while waiting for the response: drain it, no result
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_ready_low", 64'(walk_ready_o), 64'd0);
      chk("drain_no_valid", 64'(walk_valid_o), 64'd0);
      tick();
    end
    mem_if.rsp_valid = 1'b1;
    mem_if.rsp_data  = 64'h2000_0C03;
    tick();
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_data  = '0;
    chk("drain_ready_back", 64'(walk_ready_o), 64'd1);
    chk("drain_no_valid_after", 64'(walk_valid_o), 64'd0);
    chk("drain_no_req", 64'(mem_if.req_valid), 64'd0);
    tick();
    chk("drain_still_idle", 64'(walk_valid_o), 64'd0);

    // Flush in REQ before handshake: back to IDLE
    send(MPT_SMMPT43, 44'h80000, SPA_A, 1'b0);
    chk("fr_req_valid", 64'(mem_if.req_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fr_req_drop", 64'(mem_if.req_valid), 64'd0);
    chk("fr_ready", 64'(walk_ready_o), 64'd1);

    // Result backpressure: outputs held while walk_ready_i low
    send(MPT_SMMPT64, 44'h12345, 64'h0000_0000_0000_0abc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(walk_valid_o), 64'd1);
      chk("hold_fault", 64'(walk_fault_o), 64'd1);
      chk("hold_cause", 64'(walk_fault_cause_o), 64'd1);
      chk("hold_mpte", walk_mpte_o, 64'd0);
      chk("hold_spa", walk_transaction_o.spa, 64'h0abc);
      chk("hold_ppn", 64'(walk_transaction_o.mmpt.ppn), 64'h12345);
      chk("hold_ready_low", 64'(walk_ready_o), 64'd0);
      tick();
    end
    result("hold", 1'b1, 2'd1, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
